// File: rtl/dma_program_regs_if.sv
// CPU slave-mode I/O bus seen by the DMA programming register file.
// Macros: none.
//   master : CPU side, drives PROGRAM, CS_N, IOR_N, IOW_N, A, DB_IN
//   slave  : register file, drives DB_OUT, DB_OE
interface dma_program_regs_if;
  logic       PROGRAM;
  logic       CS_N;
  logic       IOR_N;
  logic       IOW_N;
  logic [3:0] A;
  logic [7:0] DB_IN;
  logic [7:0] DB_OUT;
  logic       DB_OE;

  modport master (output PROGRAM, CS_N, IOR_N, IOW_N, A, DB_IN,
                  input  DB_OUT, DB_OE);
  modport slave  (input  PROGRAM, CS_N, IOR_N, IOW_N, A, DB_IN,
                  output DB_OUT, DB_OE);
endinterface

// File: rtl/dma_program_regs.sv
// DMA programming register file. Decodes CPU I/O cycles (while PROGRAM is
// open) and holds per-channel base/current address, base/current word count
// and mode, plus global command, mask, software request and TC status.
// Multi-byte registers move through the 8-bit bus via a byte-pointer.
// Ports:
//   CLK, RESET_N            clock, async active-low reset
//   bus (slave)             CPU I/O cycle in, read data / output enable out
//   UPD_*                   timing-engine write-back of current addr/count/TC
//   CUR_ADDR, CUR_COUNT     current registers, channel 0 in the LSBs
//   MODE, COMMAND, MASK, SW_REQ, BYTE_PTR   programmed state
// Macro DMA_AUTOINIT_EN: TC write-back on an autoinit channel (MODE bit 2)
// reloads current registers from base instead of the UPD values.
module dma_program_regs #(
  parameter int CHANNELS  = 4,
  parameter int REG_WIDTH = 16,
  localparam int NBYTES = REG_WIDTH / 8,
  localparam int PW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  dma_program_regs_if.slave             bus,
  input  logic                          UPD_VALID,
  input  logic [1:0]                    UPD_CH,
  input  logic [REG_WIDTH-1:0]          UPD_ADDR,
  input  logic [REG_WIDTH-1:0]          UPD_COUNT,
  input  logic                          UPD_TC,
  output logic [CHANNELS*REG_WIDTH-1:0] CUR_ADDR,
  output logic [CHANNELS*REG_WIDTH-1:0] CUR_COUNT,
  output logic [CHANNELS*6-1:0]         MODE,
  output logic [7:0]                    COMMAND,
  output logic [CHANNELS-1:0]           MASK,
  output logic [CHANNELS-1:0]           SW_REQ,
  output logic [PW-1:0]                 BYTE_PTR
);

`ifdef DMA_AUTOINIT_EN
  localparam bit AUTOINIT = 1'b1;
`else
  localparam bit AUTOINIT = 1'b0;
`endif

  logic [REG_WIDTH-1:0] base_addr_q [CHANNELS], base_addr_d [CHANNELS];
  logic [REG_WIDTH-1:0] base_cnt_q  [CHANNELS], base_cnt_d  [CHANNELS];
  logic [REG_WIDTH-1:0] cur_addr_q  [CHANNELS], cur_addr_d  [CHANNELS];
  logic [REG_WIDTH-1:0] cur_cnt_q   [CHANNELS], cur_cnt_d   [CHANNELS];
  logic [5:0]           mode_q      [CHANNELS], mode_d      [CHANNELS];
  logic [7:0]           command_q, command_d;
  logic [CHANNELS-1:0]  mask_q, mask_d, sw_req_q, sw_req_d;
  logic [CHANNELS-1:0]  tc_q, tc_d, tc_ret_q, tc_ret_d;
  logic [PW-1:0]        ptr_q, ptr_d, ptr_inc;
  logic                 iow_prev_q;
  logic                 rd_q, rd_d;
  logic [3:0]           rd_a_q, rd_a_d;

  logic       wr_ev, rd_strobe, rd_end, db_oe;
  logic [3:0] rd_a;
  logic [1:0] wch, dch, rch;
  logic       wch_ok, dch_ok, upd_ok, rend_ok;
  logic [7:0] status, rd_data;

  // A write needs IOW_N seen high on the previous edge; the register resets
  // to 0 so a strobe held through reset cannot write on release.
  assign wr_ev     = bus.PROGRAM & ~bus.CS_N & ~bus.IOW_N & bus.IOR_N & iow_prev_q;
  assign rd_strobe = bus.PROGRAM & ~bus.CS_N & ~bus.IOR_N & bus.IOW_N;
  assign rd_a      = rd_q ? rd_a_q : bus.A;
  assign rd_end    = rd_q & bus.IOR_N;
  assign db_oe     = RESET_N & rd_strobe & (rd_a <= 4'd8);

  assign wch     = bus.A[2:1];
  assign dch     = bus.DB_IN[1:0];
  assign rch     = rd_a[2:1];
  assign wch_ok  = int'(wch) < CHANNELS;
  assign dch_ok  = int'(dch) < CHANNELS;
  assign upd_ok  = int'(UPD_CH) < CHANNELS;
  assign rend_ok = int'(rd_a_q[2:1]) < CHANNELS;
  assign ptr_inc = (ptr_q == PW'(NBYTES - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    status = '0;
    status[CHANNELS-1:0]   = tc_q;
    status[4 +: CHANNELS]  = sw_req_q;
  end

  always_comb begin
    rd_data = '0;
    if (!rd_a[3]) begin
      if (int'(rch) < CHANNELS) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (ptr_q == PW'(b))
            rd_data = rd_a[0] ? cur_cnt_q[rch][8*b +: 8] : cur_addr_q[rch][8*b +: 8];
        end
      end
    end else if (rd_a == 4'd8) begin
      rd_data = status;
    end
  end

  assign bus.DB_OE  = db_oe;
  assign bus.DB_OUT = db_oe ? rd_data : 8'h00;

  always_comb begin
    base_addr_d = base_addr_q;
    base_cnt_d  = base_cnt_q;
    cur_addr_d  = cur_addr_q;
    cur_cnt_d   = cur_cnt_q;
    mode_d      = mode_q;
    command_d   = command_q;
    mask_d      = mask_q;
    sw_req_d    = sw_req_q;
    tc_d        = tc_q;
    tc_ret_d    = tc_ret_q;
    ptr_d       = ptr_q;
    rd_d        = rd_q;
    rd_a_d      = rd_a_q;

    // Engine write-back first so a same-cycle CPU byte write overrides it.
    if (UPD_VALID && upd_ok) begin
      cur_addr_d[UPD_CH] = UPD_ADDR;
      cur_cnt_d[UPD_CH]  = UPD_COUNT;
      if (AUTOINIT && UPD_TC && mode_q[UPD_CH][2]) begin
        cur_addr_d[UPD_CH] = base_addr_q[UPD_CH];
        cur_cnt_d[UPD_CH]  = base_cnt_q[UPD_CH];
      end
    end

    if (wr_ev) begin
      if (!bus.A[3]) begin
        if (wch_ok) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (ptr_q == PW'(b)) begin
              if (!bus.A[0]) begin
                base_addr_d[wch][8*b +: 8] = bus.DB_IN;
                cur_addr_d[wch][8*b +: 8]  = bus.DB_IN;
              end else begin
                base_cnt_d[wch][8*b +: 8] = bus.DB_IN;
                cur_cnt_d[wch][8*b +: 8]  = bus.DB_IN;
              end
            end
          end
          ptr_d = ptr_inc;
        end
      end else begin
        case (bus.A[2:0])
          3'd0: command_d = bus.DB_IN;
          3'd1: if (dch_ok) sw_req_d[dch] = bus.DB_IN[2];
          3'd2: if (dch_ok) mask_d[dch] = bus.DB_IN[2];
          3'd3: if (dch_ok) mode_d[dch] = bus.DB_IN[7:2];
          3'd4: ptr_d = '0;
          3'd5: begin
            command_d = '0;
            mask_d    = '1;
            sw_req_d  = '0;
            tc_d      = '0;
            ptr_d     = '0;
          end
          3'd6: mask_d = '0;
          default: mask_d = bus.DB_IN[CHANNELS-1:0];
        endcase
      end
    end

    // Read side effects happen once, when IOR_N is first seen high again.
    if (rd_end) begin
      rd_d = 1'b0;
      if (bus.PROGRAM) begin
        if (!rd_a_q[3] && rend_ok) ptr_d = ptr_inc;
        else if (rd_a_q == 4'd8)   tc_d = tc_d & ~tc_ret_q;
      end
    end else if (!rd_q && rd_strobe) begin
      rd_d   = 1'b1;
      rd_a_d = bus.A;
    end

    // Remember the TC bits last presented so only those get cleared.
    if (db_oe && rd_a == 4'd8) tc_ret_d = tc_q;

    // TC set comes last so it wins over the status-read clear.
    if (UPD_VALID && upd_ok && UPD_TC) begin
      tc_d[UPD_CH]     = 1'b1;
      sw_req_d[UPD_CH] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < CHANNELS; i++) begin
        base_addr_q[i] <= '0;
        base_cnt_q[i]  <= '0;
        cur_addr_q[i]  <= '0;
        cur_cnt_q[i]   <= '0;
        mode_q[i]      <= '0;
      end
      command_q  <= '0;
      mask_q     <= '1;
      sw_req_q   <= '0;
      tc_q       <= '0;
      tc_ret_q   <= '0;
      ptr_q      <= '0;
      iow_prev_q <= 1'b0;
      rd_q       <= 1'b0;
      rd_a_q     <= '0;
    end else begin
      base_addr_q <= base_addr_d;
      base_cnt_q  <= base_cnt_d;
      cur_addr_q  <= cur_addr_d;
      cur_cnt_q   <= cur_cnt_d;
      mode_q      <= mode_d;
      command_q   <= command_d;
      mask_q      <= mask_d;
      sw_req_q    <= sw_req_d;
      tc_q        <= tc_d;
      tc_ret_q    <= tc_ret_d;
      ptr_q       <= ptr_d;
      iow_prev_q  <= bus.IOW_N;
      rd_q        <= rd_d;
      rd_a_q      <= rd_a_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
    assign CUR_ADDR[g*REG_WIDTH +: REG_WIDTH]  = cur_addr_q[g];
    assign CUR_COUNT[g*REG_WIDTH +: REG_WIDTH] = cur_cnt_q[g];
    assign MODE[g*6 +: 6]                      = mode_q[g];
  end

  assign COMMAND  = command_q;
  assign MASK     = mask_q;
  assign SW_REQ   = sw_req_q;
  assign BYTE_PTR = ptr_q;

endmodule

// File: tb/tb_dma_program_regs.sv
// Randomized + directed bench for dma_program_regs with a read scoreboard
// and a behavioural register model.
module tb_dma_program_regs;
  localparam int CH = 4;
  localparam int RW = 16;
  localparam int NB = RW / 8;
`ifdef DMA_AUTOINIT_EN
  localparam bit AUTOINIT = 1'b1;
`else
  localparam bit AUTOINIT = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  dma_program_regs_if bus ();
  logic           UPD_VALID, UPD_TC;
  logic [1:0]     UPD_CH;
  logic [RW-1:0]  UPD_ADDR, UPD_COUNT;
  logic [CH*RW-1:0] CUR_ADDR, CUR_COUNT;
  logic [CH*6-1:0]  MODE;
  logic [7:0]       COMMAND;
  logic [CH-1:0]    MASK, SW_REQ;
  logic [0:0]       BYTE_PTR;

  dma_program_regs #(.CHANNELS(CH), .REG_WIDTH(RW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus),
    .UPD_VALID(UPD_VALID), .UPD_CH(UPD_CH), .UPD_ADDR(UPD_ADDR),
    .UPD_COUNT(UPD_COUNT), .UPD_TC(UPD_TC),
    .CUR_ADDR(CUR_ADDR), .CUR_COUNT(CUR_COUNT), .MODE(MODE),
    .COMMAND(COMMAND), .MASK(MASK), .SW_REQ(SW_REQ), .BYTE_PTR(BYTE_PTR)
  );

  int nchk = 0;
  int npass = 0;

  // reference model
  logic [31:0] m_base_a [CH], m_base_c [CH], m_cur_a [CH], m_cur_c [CH];
  int m_mode [CH];
  int m_cmd, m_mask, m_req, m_tc, m_ptr;

  int    exp_q [$];
  string nm_q  [$];
  logic  oe_prev = 1'b0;

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endfunction

  // scoreboard monitor: one pop per read presented on the bus
  always @(negedge CLK) begin
    if (bus.DB_OE && !oe_prev) begin
      if (exp_q.size() == 0) chk("unexpected_read", 64'(bus.DB_OUT), 64'hDEAD);
      else chk(nm_q.pop_front(), 64'(bus.DB_OUT), 64'(exp_q.pop_front()));
    end
    oe_prev = bus.DB_OE;
  end

  function automatic void m_reset();
    for (int i = 0; i < CH; i++) begin
      m_base_a[i] = 0; m_base_c[i] = 0; m_cur_a[i] = 0; m_cur_c[i] = 0; m_mode[i] = 0;
    end
    m_cmd = 0; m_mask = (1 << CH) - 1; m_req = 0; m_tc = 0; m_ptr = 0;
  endfunction

  function automatic void m_wr(int a, int d);
    int ch;
    logic [31:0] mk, v;
    if (a < 8) begin
      ch = a / 2;
      if (ch < CH) begin
        mk = 32'hFF << (8 * m_ptr);
        v  = 32'(d & 8'hFF) << (8 * m_ptr);
        if (a % 2 == 0) begin
          m_base_a[ch] = (m_base_a[ch] & ~mk) | v;
          m_cur_a[ch]  = (m_cur_a[ch] & ~mk) | v;
        end else begin
          m_base_c[ch] = (m_base_c[ch] & ~mk) | v;
          m_cur_c[ch]  = (m_cur_c[ch] & ~mk) | v;
        end
        m_ptr = (m_ptr + 1) % NB;
      end
    end else begin
      ch = d & 3;
      case (a)
        8:  m_cmd = d & 8'hFF;
        9:  if (ch < CH) m_req = ((d >> 2) & 1) ? (m_req | (1 << ch)) : (m_req & ~(1 << ch));
        10: if (ch < CH) m_mask = ((d >> 2) & 1) ? (m_mask | (1 << ch)) : (m_mask & ~(1 << ch));
        11: if (ch < CH) m_mode[ch] = (d >> 2) & 8'h3F;
        12: m_ptr = 0;
        13: begin m_cmd = 0; m_mask = (1 << CH) - 1; m_req = 0; m_tc = 0; m_ptr = 0; end
        14: m_mask = 0;
        default: m_mask = d & ((1 << CH) - 1);
      endcase
    end
  endfunction

  function automatic void m_upd(int ch, int ad, int cn, bit tc);
    if (ch >= CH) return;
    if (AUTOINIT && tc && ((m_mode[ch] >> 2) & 1) == 1) begin
      m_cur_a[ch] = m_base_a[ch];
      m_cur_c[ch] = m_base_c[ch];
    end else begin
      m_cur_a[ch] = 32'(ad) & ((32'd1 << RW) - 1);
      m_cur_c[ch] = 32'(cn) & ((32'd1 << RW) - 1);
    end
    if (tc) begin
      m_tc  = m_tc | (1 << ch);
      m_req = m_req & ~(1 << ch);
    end
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic drive_upd(input int ch, input int ad, input int cn, input bit tc);
    UPD_VALID = 1'b1; UPD_CH = 2'(ch); UPD_ADDR = RW'(ad); UPD_COUNT = RW'(cn); UPD_TC = tc;
  endtask

  task automatic wr(input int a, input int d, input int hold = 1, input bit du = 0,
                    input int uch = 0, input int ua = 0, input int uc = 0, input bit utc = 0);
    bus.A = 4'(a); bus.DB_IN = 8'(d); bus.CS_N = 1'b0; bus.IOW_N = 1'b0;
    if (du) drive_upd(uch, ua, uc, utc);
    tick();
    UPD_VALID = 1'b0;
    if (du) m_upd(uch, ua, uc, utc);
    if (bus.PROGRAM) m_wr(a, d);
    repeat (hold - 1) tick();
    bus.IOW_N = 1'b1; bus.CS_N = 1'b1;
    tick();
  endtask

  task automatic upd(input int ch, input int ad, input int cn, input bit tc);
    drive_upd(ch, ad, cn, tc);
    tick();
    UPD_VALID = 1'b0;
    m_upd(ch, ad, cn, tc);
  endtask

  task automatic rd(input int a, input bit du = 0, input int uch = 0,
                    input int ua = 0, input int uc = 0, input bit utc = 0);
    int ret, ch, e;
    ret = m_tc;
    ch  = a / 2;
    if (bus.PROGRAM && a <= 8) begin
      if (a == 8) e = ((m_req << 4) | m_tc) & 8'hFF;
      else if (ch < CH) e = 32'((a % 2 == 0 ? m_cur_a[ch] : m_cur_c[ch]) >> (8 * m_ptr)) & 8'hFF;
      else e = 0;
      exp_q.push_back(e);
      nm_q.push_back($sformatf("read_a%0d", a));
    end
    bus.A = 4'(a); bus.CS_N = 1'b0; bus.IOR_N = 1'b0;
    tick(); tick();
    bus.IOR_N = 1'b1; bus.CS_N = 1'b1;
    if (du) drive_upd(uch, ua, uc, utc);
    tick();
    UPD_VALID = 1'b0;
    if (bus.PROGRAM) begin
      if (a < 8 && ch < CH) m_ptr = (m_ptr + 1) % NB;
      else if (a == 8) m_tc = m_tc & ~ret;
    end
    if (du) m_upd(uch, ua, uc, utc);
  endtask

  task automatic chk_regs(input string tag);
    logic [CH*RW-1:0] ea, ec;
    logic [CH*6-1:0]  em;
    for (int i = 0; i < CH; i++) begin
      ea[i*RW +: RW] = m_cur_a[i][RW-1:0];
      ec[i*RW +: RW] = m_cur_c[i][RW-1:0];
      em[i*6 +: 6]   = 6'(m_mode[i]);
    end
    chk({tag, ".cur_addr"},  64'(CUR_ADDR),  64'(ea));
    chk({tag, ".cur_count"}, 64'(CUR_COUNT), 64'(ec));
    chk({tag, ".mode"},      64'(MODE),      64'(em));
    chk({tag, ".command"},   64'(COMMAND),   64'(m_cmd));
    chk({tag, ".mask"},      64'(MASK),      64'(m_mask));
    chk({tag, ".sw_req"},    64'(SW_REQ),    64'(m_req));
    chk({tag, ".byte_ptr"},  64'(BYTE_PTR),  64'(m_ptr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, a;
    bus.PROGRAM = 1'b1; bus.CS_N = 1'b1; bus.IOR_N = 1'b1; bus.IOW_N = 1'b1;
    bus.A = '0; bus.DB_IN = '0;
    UPD_VALID = 1'b0; UPD_CH = '0; UPD_ADDR = '0; UPD_COUNT = '0; UPD_TC = 1'b0;
    m_reset();
    repeat (3) tick();
    chk("reset_db_oe", 64'(bus.DB_OE), 64'd0);
    chk("reset_db_out", 64'(bus.DB_OUT), 64'd0);
    RESET_N = 1'b1;
    tick();
    chk_regs("reset");
    rd(8);

    // byte-pointer sequencing on channel 1 address
    wr(12, 0); wr(2, 8'h34); wr(2, 8'h12);
    chk("ch1_addr", 64'(CUR_ADDR[RW +: RW]), 64'h1234);
    chk_regs("ch1_load");
    rd(2); rd(2);

    // held write strobe writes once
    wr(0, 8'hAA, 5);
    chk("held_ptr", 64'(BYTE_PTR), 64'd1);
    chk_regs("held");
    wr(12, 0);

    // TC status and clear-on-read
    upd(2, 16'h4000, 16'h0000, 1'b1);
    rd(8); rd(8);
    upd(1, 16'h0101, 16'h0202, 1'b1);
    rd(8, 1'b1, 1, 16'h0303, 16'h0404, 1'b1);
    rd(8); rd(8);

    // master clear
    wr(15, 8'h05); wr(8, 8'h3C);
    chk_regs("pre_mclr");
    wr(13, 0);
    chk_regs("mclr");

    // CPU byte write and engine write-back on the same channel/cycle
    wr(1, 8'h5A, 1, 1'b1, 0, 16'h1111, 16'h2222, 1'b0);
    chk("collide_cnt0", 64'(CUR_COUNT[0 +: RW]), 64'h225A);
    chk_regs("collide");
    wr(12, 0);

    // autoinit channel 0
    wr(11, 8'h10);
    wr(1, 8'h10); wr(1, 8'h00);
    upd(0, 16'hABCD, 16'h0777, 1'b1);
    chk("autoinit_cnt0", 64'(CUR_COUNT[0 +: RW]), AUTOINIT ? 64'h0010 : 64'h0777);
    chk_regs("autoinit");

    // PROGRAM closed: CPU ignored, engine still acts
    bus.PROGRAM = 1'b0;
    wr(8, 8'hFF);
    bus.A = 4'd8; bus.CS_N = 1'b0; bus.IOR_N = 1'b0;
    @(negedge CLK);
    chk("noprog_oe", 64'(bus.DB_OE), 64'd0);
    tick();
    bus.IOR_N = 1'b1; bus.CS_N = 1'b1;
    tick();
    upd(3, 16'h3333, 16'h4444, 1'b0);
    chk_regs("noprog");
    bus.PROGRAM = 1'b1;
    tick();

    // reset mid write strobe
    bus.A = 4'd8; bus.DB_IN = 8'h55; bus.CS_N = 1'b0; bus.IOW_N = 1'b0;
    tick();
    RESET_N = 1'b0;
    m_reset();
    #1;
    chk_regs("async_rst");
    tick();
    RESET_N = 1'b1;
    repeat (3) tick();
    chk("rst_held_cmd", 64'(COMMAND), 64'd0);
    bus.IOW_N = 1'b1; bus.CS_N = 1'b1;
    tick();

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 7);
      case (op)
        0, 1: wr($urandom_range(0, 7), $urandom_range(0, 255));
        2, 3: rd($urandom_range(0, 9));
        4:    wr($urandom_range(9, 11), $urandom_range(0, 255));
        5:    upd($urandom_range(0, 3), $urandom, $urandom, 1'($urandom_range(0, 1)));
        6:    wr($urandom_range(12, 15), $urandom_range(0, 255));
        default: wr(8, $urandom_range(0, 255));
      endcase
      chk_regs($sformatf("rand%0d", it));
    end

    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/dma_program_regs.md
Name: dma_program_regs

Overview:
- Parametrised DMA programming register file: decodes CPU slave-mode I/O cycles and holds all programmed channel state.
- Per-channel registers: base/current address, base/current word count, mode. Global registers: command, mask, software request, status (TC/request).
- Multi-byte registers load and read over the 8-bit data bus through a generalised byte-pointer flip-flop.
- Sits between the bus interface and the DMA timing engine; the engine writes back updated current address/count and terminal count.

Parameters:
- CHANNELS, 4, number of channels, 1..4; channel field is always DB[1:0]/A[2:1]; accesses to channel >= CHANNELS are ignored (reads return 8'h00).
- REG_WIDTH, 16, address/word-count width, one of 16, 24, 32; NBYTES = REG_WIDTH/8.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- PROGRAM  in  1  programming window open (DMA idle); decode is gated by it
- CS_N  in  1  chip select, active low
- IOR_N  in  1  I/O read strobe, active low
- IOW_N  in  1  I/O write strobe, active low
- A  in  4  register address A3..A0
- DB_IN  in  8  CPU write data
- DB_OUT  out  8  CPU read data
- DB_OE  out  1  drive DB_OUT onto bus
- UPD_VALID  in  1  engine write-back strobe
- UPD_CH  in  2  write-back channel
- UPD_ADDR  in  REG_WIDTH  new current address
- UPD_COUNT  in  REG_WIDTH  new current word count
- UPD_TC  in  1  terminal count reached on UPD_CH
- CUR_ADDR  out  CHANNELS*REG_WIDTH  current address, channel 0 in LSBs
- CUR_COUNT  out  CHANNELS*REG_WIDTH  current word count, flattened the same way
- MODE  out  CHANNELS*6  mode = written DB[7:2]
- COMMAND  out  8  command register
- MASK  out  CHANNELS  channel mask bits
- SW_REQ  out  CHANNELS  software request bits
- BYTE_PTR  out  $clog2(NBYTES)  byte pointer, exported for checking

Behaviour:
- Reset (async, RESET_N=0) values: all base/current/mode = 0, COMMAND=0, MASK=all 1, SW_REQ=0, TC=0, BYTE_PTR=0, DB_OUT=0, DB_OE=0.
- Address map:
  - A3=0: channel register, channel = A[2:1]; A0=0 address, A0=1 word count.
  - A=8: write command / read status.
  - A=9: request write, DB[2] set/clear for channel DB[1:0].
  - A=10: single mask write, DB[2] set/clear for channel DB[1:0].
  - A=11: mode write.
  - A=12: clear byte pointer.
  - A=13: master clear.
  - A=14: clear all masks.
  - A=15: write all masks from DB[CHANNELS-1:0].
- Write event:
  - Fires for exactly one cycle: the first sampled cycle with PROGRAM & !CS_N & !IOW_N & IOR_N, after a cycle with IOW_N high.
  - Registers update on that edge; a held strobe never writes twice.
- Channel register write: DB_IN goes into byte BYTE_PTR of both the base and current register. BYTE_PTR then increments, wrapping NBYTES-1 -> 0.
- Read:
  - DB_OE=1 and DB_OUT valid combinationally while PROGRAM & !CS_N & !IOR_N & IOW_N & A readable (0-8).
  - Channel reads return byte BYTE_PTR of the current register.
  - Read target is latched on the strobe's first cycle.
  - On the first cycle IOR_N is sampled high again: BYTE_PTR increments for channel reads; status read clears the TC bits that were returned.
- Status byte: [7:4] SW_REQ zero-extended, [3:0] TC zero-extended.
- Master clear: same as reset for COMMAND, MASK, SW_REQ, TC, BYTE_PTR. Base/current/mode are untouched.
- Engine write-back: when UPD_VALID is high, the current address/count of UPD_CH load UPD_ADDR/UPD_COUNT. If UPD_TC is also high, TC[UPD_CH] is set and SW_REQ[UPD_CH] is cleared.
- Simultaneous events:
  - CPU channel write and UPD_VALID on the same channel in one cycle: the CPU byte write wins for that byte; other bytes take UPD values.
  - TC set and status-read clear on the same bit: set wins.
- PROGRAM=0: all CPU writes and reads are ignored, DB_OE=0. UPD_VALID still acts.
- Reset asserted mid-strobe: everything returns to reset values immediately. The strobe in progress does not write after release unless IOW_N returns high first.

Optional Feature:
- DMA_AUTOINIT_EN defined: on UPD_VALID & UPD_TC with MODE[ch][2]=1 (DB[4], autoinitialise), current address/count reload from base instead of UPD values. TC is still set; SW_REQ is cleared.
- Undefined: the mode bit is stored but has no effect; current registers always take UPD values.

Test Plan:
- Reset, then read A=8 -> DB_OUT=8'h00; MASK=4'hF; BYTE_PTR=0.
- A=12 clear, write A=2 bytes 8'h34 then 8'h12 -> CUR_ADDR ch1 = 16'h1234, BYTE_PTR=0; two reads of A=2 return 8'h34, 8'h12.
- IOW_N held low 5 cycles writing A=0 with 8'hAA -> only byte 0 written, BYTE_PTR=1.
- UPD_VALID, UPD_CH=2, UPD_TC=1 -> status read returns 8'h04; second status read returns 8'h00; TC set coincident with the read's end stays 1.
- A=13 after A=15 write 8'h05 and A=8 write 8'h3C -> MASK=4'hF, COMMAND=0, CUR_ADDR unchanged.
- DMA_AUTOINIT_EN: mode 8'h10 ch0, base count 16'h0010, UPD_TC -> CUR_COUNT ch0 = 16'h0010; without the macro = UPD_COUNT.
